rv_fifo_buffer: RTL and testbench
=================================

Name: rv_fifo_buffer

Overview:
- Parametrised ready/valid FIFO buffer, inserted between a producer (Generator-style) and a consumer (Checker-style) on a data stream.
- Generalises the fixed 8-bit direct producer/consumer link: configurable width and depth, elastic storage, occupancy reporting, almost-full flag and synchronous flush.
- Used in unit-test benches and in datapaths that need rate decoupling.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
DEPTH, 4, number of storage entries (>=2; need not be a power of two)
ALMOST_FULL_LEVEL, 3, level at or above which almost_full asserts (1..DEPTH)

Ports:
clock_port  input  1  single clock; all state updates on rising edge
reset_port  input  1  asynchronous, active-low reset
input_port_data  input  DATA_WIDTH  upstream payload
input_port_valid  input  1  upstream valid
input_port_ready  output  1  buffer can accept an entry this cycle
output_port_data  output  DATA_WIDTH  downstream payload (head entry)
output_port_valid  output  1  buffer holds at least one entry
output_port_ready  input  1  downstream accepts head entry
flush  input  1  synchronous clear of all stored entries
level  output  CW  current occupancy, CW = clog2(DEPTH+1)
almost_full  output  1  level >= ALMOST_FULL_LEVEL

Behaviour:
- Reset (reset_port=0, asynchronous): wr_ptr=0, rd_ptr=0, level=0, output_port_valid=0, input_port_ready=0, almost_full=0.
- Storage contents are not reset.
- input_port_ready is a register. It rises to 1 on the first rising edge after reset_port deasserts. It is never combinationally dependent on output_port_ready.
- Push: input_port_valid && input_port_ready at a rising edge.
  - Writes input_port_data to mem[wr_ptr].
  - wr_ptr advances; it wraps from DEPTH-1 to 0.
- Pop: output_port_valid && output_port_ready at a rising edge.
  - rd_ptr advances with the same wrap rule.
- Level update per edge (absent flush):
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Registered flags, derived from the next level:
  - output_port_valid = (level != 0)
  - input_port_ready = (level != DEPTH)
  - almost_full = (level >= ALMOST_FULL_LEVEL)
- Latency: an entry pushed at edge N is visible at the output (valid=1) in the cycle after edge N. There is no combinational input-to-output bypass.
- output_port_data = mem[rd_ptr].
  - Held stable while output_port_valid=1 and output_port_ready=0.
  - Don't-care while output_port_valid=0; benches must not check it then.
- Full (level=DEPTH): input_port_ready=0.
  - A pop in this cycle makes ready=1 from the next cycle onward.
  - There is no same-cycle push on a full buffer.
- Empty (level=0): output_port_valid=0.
  - output_port_ready is ignored.
  - A push makes valid=1 from the next cycle onward.
- Push and pop in the same cycle at a partially full level: both take effect; level is unchanged; the flags hold their values.
- flush=1 at an edge:
  - Effect: pointers=0, level=0, output_port_valid=0, almost_full=0, input_port_ready=1 on the next cycle.
  - Priority: flush overrides any push/pop in that cycle; those transfers are discarded.
  - The handshake during flush is not a transfer. Upstream must treat the push as lost; downstream must treat the pop as not delivered.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values. Buffered entries are lost.
- Ordering: strict FIFO. No entry is duplicated or dropped except by flush or reset.

Test Plan:
- Reset and ready timing (DEPTH=4):
  - Stimulus: hold reset_port=0 for 3 cycles, then release.
  - Required: input_port_ready=0 and output_port_valid=0 throughout reset; ready=1 from the first edge after release; level=0.
- Fill to full:
  - Stimulus: push 0x11, 0x22, 0x33, 0x44 with output_port_ready=0.
  - Required: level steps 1,2,3,4; almost_full=1 once level=3; input_port_ready=0 at level 4; output_port_data=0x11 held steady.
- Drain and wrap:
  - Stimulus: from full, set output_port_ready=1 for 4 cycles, then push 0x55 and 0x66 and pop them.
  - Required: outputs appear in order 0x11..0x44, then 0x55, 0x66 with pointers wrapped; output_port_valid=0 when level=0.
- Simultaneous push/pop at level 2:
  - Stimulus: input_port_valid=1 and output_port_ready=1 for 10 cycles with incrementing data 0x00..0x09.
  - Required: level stays 2; output order continues monotonically with no gaps.
- Flush with concurrent handshake:
  - Stimulus: at level 3, assert flush together with a push of 0xAA and a pop.
  - Required: next cycle level=0, output_port_valid=0, almost_full=0, input_port_ready=1; 0xAA never appears at the output.
- Async reset mid-stream:
  - Stimulus: at level 2, drop reset_port between clock edges.
  - Required: level=0 and output_port_valid=0 immediately, without waiting for an edge; after release, a push of 0x5A then a pop returns 0x5A.

Source files
------------

// File: rtl/rv_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rv_fifo_buffer
// Purpose  : Ready/valid elastic FIFO with occupancy, almost-full and flush.
// Revision : 1.0  initial release
// ============================================================================
module rv_fifo_buffer #(
   parameter int DATA_WIDTH        = 8,
   parameter int DEPTH             = 4,
   parameter int ALMOST_FULL_LEVEL = 3
) (
   input  logic                       clock_port,
   input  logic                       reset_port,
   input  logic [DATA_WIDTH-1:0]      input_port_data,
   input  logic                       input_port_valid,
   output logic                       input_port_ready,
   output logic [DATA_WIDTH-1:0]      output_port_data,
   output logic                       output_port_valid,
   input  logic                       output_port_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       almost_full
);

   localparam int              c_CW   = $clog2(DEPTH+1);
   localparam int              c_PW   = $clog2(DEPTH);
   localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_AF   = c_CW'(ALMOST_FULL_LEVEL);
   localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH-1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_PW-1:0]       r_wr_ptr;
   logic [c_PW-1:0]       r_rd_ptr;
   logic [c_CW-1:0]       r_level;
   logic [c_CW-1:0]       w_level_nxt;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_almost_full;
   logic                  w_push;
   logic                  w_pop;

   // Pointer advance with explicit wrap so DEPTH need not be a power of two.
   function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
      return (p == c_LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_push = input_port_valid & r_in_ready;
   assign w_pop  = output_port_ready & r_out_valid;

   always_comb begin
      w_level_nxt = r_level;
      if (flush)
         w_level_nxt = '0;
      else if (w_push && !w_pop)
         w_level_nxt = r_level + 1'b1;
      else if (w_pop && !w_push)
         w_level_nxt = r_level - 1'b1;
   end

   always_ff @(posedge clock_port or negedge reset_port) begin
      if (!reset_port) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_in_ready    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_almost_full <= 1'b0;
      end else begin
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
         end
         // Flags are registered from the next level, so ready never depends on the sink.
         r_level       <= w_level_nxt;
         r_out_valid   <= (w_level_nxt != '0);
         r_in_ready    <= (w_level_nxt != c_FULL);
         r_almost_full <= (w_level_nxt >= c_AF);
      end
   end

   always_ff @(posedge clock_port) begin
      if (w_push && !flush)
         r_mem[r_wr_ptr] <= input_port_data;
   end

   assign input_port_ready  = r_in_ready;
   assign output_port_valid = r_out_valid;
   assign output_port_data  = r_mem[r_rd_ptr];
   assign level             = r_level;
   assign almost_full       = r_almost_full;

endmodule
`default_nettype wire

// File: tb/tb_rv_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_fifo_buffer
// Purpose  : Self-checking bench: vector table, corner sequences, random vs queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rv_fifo_buffer;

   localparam int c_DEPTH = 4;
   localparam int c_AFL   = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_d = '0;
   logic       in_v = 1'b0;
   logic       in_r;
   logic [7:0] out_d;
   logic       out_v;
   logic       out_r = 1'b0;
   logic       fl = 1'b0;
   logic [2:0] lvl;
   logic       af;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: contents as a queue, plus the registered ready flag.
   logic [7:0] m_q[$];
   logic       m_rdy = 1'b0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ordy;
      logic       fl;
      int         lvl;
      logic       ov;
      logic       ir;
      logic       af;
      logic [7:0] od;
   } vec_t;

   vec_t tbl[$];

   rv_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(c_DEPTH), .ALMOST_FULL_LEVEL(c_AFL)) dut (
      .clock_port        (clk),
      .reset_port        (rst_n),
      .input_port_data   (in_d),
      .input_port_valid  (in_v),
      .input_port_ready  (in_r),
      .output_port_data  (out_d),
      .output_port_valid (out_v),
      .output_port_ready (out_r),
      .flush             (fl),
      .level             (lvl),
      .almost_full       (af)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic v, logic [7:0] d, logic ordy, logic f,
                               int l, logic ov, logic ir, logic a, logic [7:0] od);
      vec_t t;
      t.v = v; t.d = d; t.ordy = ordy; t.fl = f;
      t.lvl = l; t.ov = ov; t.ir = ir; t.af = a; t.od = od;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   // Apply inputs for one cycle, advance the model, sample #1 after the edge.
   task automatic tick(input logic v, input logic [7:0] d, input logic ordy, input logic f);
      logic do_push, do_pop;
      in_v = v; in_d = d; out_r = ordy; fl = f;
      do_push = v && m_rdy;
      do_pop  = (m_q.size() != 0) && ordy;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_q.delete();
         m_rdy = 1'b0;
      end else begin
         if (f) m_q.delete();
         else begin
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(d);
         end
         m_rdy = (m_q.size() != c_DEPTH);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".level"}, 32'(lvl), 32'(m_q.size()));
      chk({tag, ".valid"}, 32'(out_v), 32'(m_q.size() != 0));
      chk({tag, ".ready"}, 32'(in_r), 32'(m_rdy));
      chk({tag, ".af"},    32'(af), 32'(m_q.size() >= c_AFL));
      if (m_q.size() != 0) chk({tag, ".data"}, 32'(out_d), 32'(m_q[0]));
   endtask

   initial begin
      // Reset held for three cycles: ready and valid stay low.
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 8'h00, 1'b0, 1'b0);
         chk("rst.ready", 32'(in_r), 32'd0);
         chk("rst.valid", 32'(out_v), 32'd0);
         chk("rst.level", 32'(lvl), 32'd0);
      end
      rst_n = 1'b1;
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      chk("rel.ready", 32'(in_r), 32'd1);
      chk("rel.level", 32'(lvl), 32'd0);
      chk("rel.valid", 32'(out_v), 32'd0);

      // Fill, overfill attempt, drain, empty pop, wrap-around traffic.
      tbl.push_back(mk(1, 8'h11, 0, 0, 1, 1, 1, 0, 8'h11));
      tbl.push_back(mk(1, 8'h22, 0, 0, 2, 1, 1, 0, 8'h11));
      tbl.push_back(mk(1, 8'h33, 0, 0, 3, 1, 1, 1, 8'h11));
      tbl.push_back(mk(1, 8'h44, 0, 0, 4, 1, 0, 1, 8'h11));
      tbl.push_back(mk(1, 8'h99, 0, 0, 4, 1, 0, 1, 8'h11));
      tbl.push_back(mk(0, 8'h00, 1, 0, 3, 1, 1, 1, 8'h22));
      tbl.push_back(mk(0, 8'h00, 1, 0, 2, 1, 1, 0, 8'h33));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0, 8'h44));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00));
      tbl.push_back(mk(1, 8'h55, 0, 0, 1, 1, 1, 0, 8'h55));
      tbl.push_back(mk(1, 8'h66, 0, 0, 2, 1, 1, 0, 8'h55));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0, 8'h66));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00));
      foreach (tbl[i]) begin
         tick(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         chk($sformatf("vec%0d.level", i), 32'(lvl), 32'(tbl[i].lvl));
         chk($sformatf("vec%0d.valid", i), 32'(out_v), 32'(tbl[i].ov));
         chk($sformatf("vec%0d.ready", i), 32'(in_r), 32'(tbl[i].ir));
         chk($sformatf("vec%0d.af", i), 32'(af), 32'(tbl[i].af));
         if (tbl[i].ov) chk($sformatf("vec%0d.data", i), 32'(out_d), 32'(tbl[i].od));
      end

      // Simultaneous push/pop at level 2: level constant, stream continuous.
      tick(1'b1, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 8'(i + 2), 1'b1, 1'b0);
         chk("pp.level", 32'(lvl), 32'd2);
         chk("pp.data", 32'(out_d), 32'(i + 1));
         chk("pp.ready", 32'(in_r), 32'd1);
      end

      // Flush at level 3 with a concurrent push of 0xAA and a pop.
      tick(1'b1, 8'h0C, 1'b0, 1'b0);
      chk("pre_flush.level", 32'(lvl), 32'd3);
      tick(1'b1, 8'hAA, 1'b1, 1'b1);
      chk("flush.level", 32'(lvl), 32'd0);
      chk("flush.valid", 32'(out_v), 32'd0);
      chk("flush.af", 32'(af), 32'd0);
      chk("flush.ready", 32'(in_r), 32'd1);
      tick(1'b1, 8'h5B, 1'b0, 1'b0);
      chk("post_flush.data", 32'(out_d), 32'h5B);
      chk("post_flush.level", 32'(lvl), 32'd1);
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_flush.empty", 32'(out_v), 32'd0);

      // Asynchronous reset between edges at level 2.
      tick(1'b1, 8'h21, 1'b0, 1'b0);
      tick(1'b1, 8'h22, 1'b0, 1'b0);
      chk("pre_arst.level", 32'(lvl), 32'd2);
      in_v = 1'b0; out_r = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst.level", 32'(lvl), 32'd0);
      chk("arst.valid", 32'(out_v), 32'd0);
      chk("arst.ready", 32'(in_r), 32'd0);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      chk("arel.ready", 32'(in_r), 32'd1);
      tick(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("arel.valid", 32'(out_v), 32'd1);
      chk("arel.data", 32'(out_d), 32'h5A);
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      chk("arel.empty", 32'(out_v), 32'd0);

      // Randomised traffic against the queue model.
      for (int i = 0; i < 600; i++) begin
         tick(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0));
         chk_model($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
